ccip_mem_responder: RTL and testbench

Memory-side responder for the CCI-P-style request/response interface driven by the team's AFUs.
- Accepts c0 read-line and c1 write-line requests, backs them with a local line-addressed RAM, and returns c0 read-data and c1 write-completion responses.
- Drives almost-full backpressure to the requester.
- Used as the FIU/host stand-in in AFU unit benches and in loopback builds.

---
 rtl/ccip_mem_responder_pkg.sv | 32 +++
 rtl/ccip_req_fifo.sv | 66 ++++++
 rtl/ccip_mem_responder.sv | 158 +++++++++++++++
 tb/tb_ccip_mem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_mem_responder_pkg.sv
// Shared types for the CCI-P memory responder: request encodings, line/tag/address
// widths and the queue and read-pipeline entry layouts.
package ccip_mem_responder_pkg;

    typedef enum logic [3:0] {
        WRLINE_I = 4'h1,
        RDLINE_I = 4'h4,
        RDLINE_S = 4'h5
    } t_req_type;

    typedef logic [511:0] t_line;
    typedef logic [15:0]  t_mdata;
    typedef logic [41:0]  t_cl_addr;

    typedef struct packed {
        t_cl_addr addr;
        t_mdata   mdata;
    } t_c0_req;

    typedef struct packed {
        t_cl_addr addr;
        t_mdata   mdata;
        t_line    data;
    } t_c1_req;

    typedef struct packed {
        logic   valid;
        t_mdata mdata;
        t_line  data;
    } t_rd_pipe;

endpackage

// File: rtl/ccip_req_fifo.sv
// Synchronous request queue with occupancy count, full/empty flags and a
// registered almost-full flag. Pushes into a full queue are discarded.
module ccip_req_fifo #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEPTH_LOG2     = 6,
    parameter int unsigned ALMFULL_THRESH = 56
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almfull
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  almfull_q, almfull_d;
    logic                  do_push, do_pop;

    always_comb begin
        full      = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
        empty     = (count_q == '0);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        wr_ptr_d  = do_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d   = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        else if (!do_push && do_pop)
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        // Flag follows the occupancy seen during the current cycle, one edge late.
        almfull_d = (32'(count_q) >= ALMFULL_THRESH);
        pop_data  = mem_q[rd_ptr_q];
        count     = count_q;
        almfull   = almfull_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            almfull_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            almfull_q <= almfull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ccip_mem_responder.sv
// Memory-side CCI-P responder: queues c0 reads and c1 writes, services them from a
// local line RAM and returns in-order read data and write completions.
module ccip_mem_responder
    import ccip_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES_LOG2  = 10,
    parameter int unsigned RD_LATENCY      = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 6,
    parameter int unsigned ALMFULL_THRESH  = 56
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c0_req_valid,
    input  logic [3:0]    c0_req_type,
    input  logic [41:0]   c0_req_addr,
    input  logic [15:0]   c0_req_mdata,
    output logic          c0_almfull,
    output logic          c0_rsp_valid,
    output logic [15:0]   c0_rsp_mdata,
    output logic [511:0]  c0_rsp_data,
    input  logic          c1_req_valid,
    input  logic [41:0]   c1_req_addr,
    input  logic [15:0]   c1_req_mdata,
    input  logic [511:0]  c1_req_data,
    output logic          c1_almfull,
    output logic          c1_rsp_valid,
    output logic [15:0]   c1_rsp_mdata,
    input  logic          rsp_stall,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt,
    output logic          err_overflow,
    output logic          err_bad_type
);
    localparam int unsigned LINES = 1 << MEM_LINES_LOG2;

    t_line    ram_q [LINES];
    t_c0_req  c0_head;
    t_c1_req  c1_head;
    logic     c0_push, c0_pop, c0_full, c0_empty, c0_type_ok;
    logic     c1_push, c1_pop, c1_full, c1_empty;
    logic [FIFO_DEPTH_LOG2:0]  c0_count, c1_count;
    logic [MEM_LINES_LOG2-1:0] rd_idx, wr_idx;

    t_rd_pipe rd_stage_q, rd_stage_d;
    t_rd_pipe pipe_q [RD_LATENCY];
    t_rd_pipe pipe_d [RD_LATENCY];
    logic          c1_rsp_valid_q, c1_rsp_valid_d;
    t_mdata        c1_rsp_mdata_q, c1_rsp_mdata_d;
    logic [31:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_bad_type_q, err_bad_type_d;

    ccip_req_fifo #(
        .WIDTH          ($bits(t_c0_req)),
        .DEPTH_LOG2     (FIFO_DEPTH_LOG2),
        .ALMFULL_THRESH (ALMFULL_THRESH)
    ) u_c0_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (c0_push),
        .push_data ({c0_req_addr, c0_req_mdata}),
        .pop       (c0_pop),
        .pop_data  (c0_head),
        .count     (c0_count),
        .full      (c0_full),
        .empty     (c0_empty),
        .almfull   (c0_almfull)
    );

    ccip_req_fifo #(
        .WIDTH          ($bits(t_c1_req)),
        .DEPTH_LOG2     (FIFO_DEPTH_LOG2),
        .ALMFULL_THRESH (ALMFULL_THRESH)
    ) u_c1_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (c1_push),
        .push_data ({c1_req_addr, c1_req_mdata, c1_req_data}),
        .pop       (c1_pop),
        .pop_data  (c1_head),
        .count     (c1_count),
        .full      (c1_full),
        .empty     (c1_empty),
        .almfull   (c1_almfull)
    );

    always_comb begin
        c0_type_ok = (c0_req_type == RDLINE_I) || (c0_req_type == RDLINE_S);
        c0_push    = c0_req_valid && c0_type_ok;
        c1_push    = c1_req_valid;
        c0_pop     = !c0_empty && !rsp_stall;
        c1_pop     = !c1_empty && !rsp_stall;
        rd_idx     = c0_head.addr[MEM_LINES_LOG2-1:0];
        wr_idx     = c1_head.addr[MEM_LINES_LOG2-1:0];

        // Same-line write popping alongside the read is forwarded (write-first).
        rd_stage_d = '0;
        if (c0_pop) begin
            rd_stage_d.valid = 1'b1;
            rd_stage_d.mdata = c0_head.mdata;
            rd_stage_d.data  = (c1_pop && (wr_idx == rd_idx)) ? c1_head.data : ram_q[rd_idx];
        end

        pipe_d[0] = rd_stage_q;
        for (int unsigned i = 1; i < RD_LATENCY; i++)
            pipe_d[i] = pipe_q[i-1];

        c1_rsp_valid_d = c1_pop;
        c1_rsp_mdata_d = c1_pop ? c1_head.mdata : '0;
        rd_cnt_d       = rd_cnt_q + 32'(pipe_q[RD_LATENCY-2].valid);
        wr_cnt_d       = wr_cnt_q + 32'(c1_pop);
        err_overflow_d = err_overflow_q | (c0_push && c0_full) | (c1_push && c1_full);
        err_bad_type_d = err_bad_type_q | (c0_req_valid && !c0_type_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stage_q     <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++)
                pipe_q[i] <= '0;
            c1_rsp_valid_q <= 1'b0;
            c1_rsp_mdata_q <= '0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            err_overflow_q <= 1'b0;
            err_bad_type_q <= 1'b0;
        end else begin
            rd_stage_q     <= rd_stage_d;
            for (int unsigned i = 0; i < RD_LATENCY; i++)
                pipe_q[i] <= pipe_d[i];
            c1_rsp_valid_q <= c1_rsp_valid_d;
            c1_rsp_mdata_q <= c1_rsp_mdata_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            err_overflow_q <= err_overflow_d;
            err_bad_type_q <= err_bad_type_d;
        end
    end

    // RAM contents survive reset; only the write that would pop on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && c1_pop)
            ram_q[wr_idx] <= c1_head.data;
    end

    always_comb begin
        c0_rsp_valid = pipe_q[RD_LATENCY-1].valid;
        c0_rsp_mdata = pipe_q[RD_LATENCY-1].mdata;
        c0_rsp_data  = pipe_q[RD_LATENCY-1].data;
        c1_rsp_valid = c1_rsp_valid_q;
        c1_rsp_mdata = c1_rsp_mdata_q;
        rd_cnt       = rd_cnt_q;
        wr_cnt       = wr_cnt_q;
        err_overflow = err_overflow_q;
        err_bad_type = err_bad_type_q;
    end

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Scoreboard bench for ccip_mem_responder: directed requests push expected responses,
// an independent monitor pops and compares whenever a response strobe is seen.
module tb_ccip_mem_responder;
    import ccip_mem_responder_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         c0_req_valid = 1'b0;
    logic [3:0]   c0_req_type = 4'h4;
    logic [41:0]  c0_req_addr = '0;
    logic [15:0]  c0_req_mdata = '0;
    logic         c0_almfull, c0_rsp_valid;
    logic [15:0]  c0_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         c1_req_valid = 1'b0;
    logic [41:0]  c1_req_addr = '0;
    logic [15:0]  c1_req_mdata = '0;
    logic [511:0] c1_req_data = '0;
    logic         c1_almfull, c1_rsp_valid;
    logic [15:0]  c1_rsp_mdata;
    logic         rsp_stall = 1'b0;
    logic [31:0]  rd_cnt, wr_cnt;
    logic         err_overflow, err_bad_type;

    ccip_mem_responder #(
        .MEM_LINES_LOG2  (10),
        .RD_LATENCY      (8),
        .FIFO_DEPTH_LOG2 (6),
        .ALMFULL_THRESH  (56)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .c0_req_valid (c0_req_valid),
        .c0_req_type  (c0_req_type),
        .c0_req_addr  (c0_req_addr),
        .c0_req_mdata (c0_req_mdata),
        .c0_almfull   (c0_almfull),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_mdata (c0_rsp_mdata),
        .c0_rsp_data  (c0_rsp_data),
        .c1_req_valid (c1_req_valid),
        .c1_req_addr  (c1_req_addr),
        .c1_req_mdata (c1_req_mdata),
        .c1_req_data  (c1_req_data),
        .c1_almfull   (c1_almfull),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_mdata (c1_rsp_mdata),
        .rsp_stall    (rsp_stall),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt),
        .err_overflow (err_overflow),
        .err_bad_type (err_bad_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  mdata;
        logic [511:0] data;
        int unsigned  lat;
        int unsigned  issue;
    } rd_exp_t;

    rd_exp_t     exp_rd[$];
    logic [15:0] exp_wr[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned c0_rsp_n = 0;

    localparam logic [511:0] DATA_A5 = {64{8'hA5}};
    localparam logic [511:0] DATA_11 = {64{8'h11}};
    localparam logic [511:0] DATA_22 = {64{8'h22}};
    localparam logic [511:0] DATA_3C = {64{8'h3C}};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (c0_rsp_valid === 1'b1) begin
            c0_rsp_n++;
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL c0_unexpected mdata=%0h (no response expected)", c0_rsp_mdata);
            end else begin
                rd_exp_t e;
                e = exp_rd.pop_front();
                if (c0_rsp_mdata !== e.mdata || c0_rsp_data !== e.data ||
                    (e.lat != 0 && cyc - e.issue != e.lat)) begin
                    errors++;
                    $display("FAIL c0_rsp got mdata=%0h lat=%0d data=%0h expected mdata=%0h lat=%0d data=%0h",
                             c0_rsp_mdata, cyc - e.issue, c0_rsp_data, e.mdata, e.lat, e.data);
                end
            end
        end
        if (c1_rsp_valid === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL c1_unexpected mdata=%0h (no response expected)", c1_rsp_mdata);
            end else begin
                logic [15:0] m;
                m = exp_wr.pop_front();
                if (c1_rsp_mdata !== m) begin
                    errors++;
                    $display("FAIL c1_rsp got mdata=%0h expected %0h", c1_rsp_mdata, m);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a c0 request for the next edge; the scoreboard entry records that edge number.
    task automatic set_rd(input logic [41:0] a, input logic [15:0] m, input logic [3:0] t,
                          input bit expect_rsp, input logic [511:0] d, input int unsigned lat);
        rd_exp_t e;
        c0_req_valid = 1'b1;
        c0_req_addr  = a;
        c0_req_mdata = m;
        c0_req_type  = t;
        if (expect_rsp) begin
            e.mdata = m;
            e.data  = d;
            e.lat   = lat;
            e.issue = cyc + 1;
            exp_rd.push_back(e);
        end
    endtask

    task automatic set_wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
        c1_req_valid = 1'b1;
        c1_req_addr  = a;
        c1_req_mdata = m;
        c1_req_data  = d;
        exp_wr.push_back(m);
    endtask

    task automatic step();
        @(negedge clk);
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) step();
    endtask

    initial begin
        int unsigned rsp_before;
        int unsigned almfull_seen;

        repeat (3) @(negedge clk);
        chk("rst_c0_rsp_valid", 64'(c0_rsp_valid), 64'd0);
        chk("rst_c1_rsp_valid", 64'(c1_rsp_valid), 64'd0);
        chk("rst_almfull", 64'({c0_almfull, c1_almfull}), 64'd0);
        chk("rst_counters", {rd_cnt, wr_cnt}, 64'd0);
        chk("rst_err", 64'({err_overflow, err_bad_type}), 64'd0);
        reset = 1'b0;
        idle(2);

        // Basic write then read of line 0x10, read latency 9 from the request edge
        set_wr(42'h10, 16'h0001, DATA_A5);
        step();
        idle(4);
        set_rd(42'h10, 16'h0002, RDLINE_I, 1'b1, DATA_A5, 9);
        step();
        idle(12);
        chk("basic_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("basic_rd_cnt", 64'(rd_cnt), 64'd1);

        // Same-cycle read and write to line 5
        set_wr(42'h5, 16'h0003, DATA_11);
        step();
        idle(3);
        set_rd(42'h5, 16'h0004, RDLINE_S, 1'b1, DATA_22, 9);
        set_wr(42'h5, 16'h0005, DATA_22);
        step();
        idle(12);

        // Aliasing: 0x400 wraps onto line 0
        set_wr(42'h400, 16'h0006, DATA_3C);
        step();
        idle(3);
        set_rd(42'h0, 16'h0007, RDLINE_I, 1'b1, DATA_3C, 9);
        step();
        idle(12);
        chk("alias_rd_cnt", 64'(rd_cnt), 64'd3);

        // Backpressure: fill the read queue under stall
        rsp_stall = 1'b1;
        for (int i = 0; i < 56; i++) begin
            set_rd(42'h10, 16'(i), RDLINE_I, 1'b1, DATA_A5, 0);
            step();
        end
        chk("almfull_same_cycle", 64'(c0_almfull), 64'd0);
        step();
        chk("almfull_next_cycle", 64'(c0_almfull), 64'd1);
        for (int i = 56; i < 64; i++) begin
            set_rd(42'h10, 16'(i), RDLINE_I, 1'b1, DATA_A5, 0);
            step();
        end
        chk("ovf_before_full_push", 64'(err_overflow), 64'd0);
        set_rd(42'h10, 16'd64, RDLINE_I, 1'b0, DATA_A5, 0);
        step();
        chk("ovf_after_65th", 64'(err_overflow), 64'd1);
        chk("c1_almfull_idle", 64'(c1_almfull), 64'd0);
        chk("stall_no_rsp", 64'(rd_cnt), 64'd3);
        rsp_stall = 1'b0;
        idle(80);
        chk("drain_rd_cnt", 64'(rd_cnt), 64'd67);
        chk("drain_wr_cnt", 64'(wr_cnt), 64'd4);
        chk("drain_almfull", 64'(c0_almfull), 64'd0);
        chk("drain_rd_pending", 64'(exp_rd.size()), 64'd0);

        // Non-read type on c0 is dropped
        rsp_before = c0_rsp_n;
        set_rd(42'h10, 16'h0BAD, WRLINE_I, 1'b0, DATA_A5, 0);
        step();
        chk("bad_type_flag", 64'(err_bad_type), 64'd1);
        idle(12);
        chk("bad_type_no_rsp", 64'(c0_rsp_n - rsp_before), 64'd0);

        // Reset with three reads in flight
        for (int i = 0; i < 3; i++) begin
            set_rd(42'h10, 16'(16'h100 + i), RDLINE_I, 1'b0, DATA_A5, 0);
            step();
        end
        rsp_before = c0_rsp_n;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(15);
        chk("rst_inflight_no_rsp", 64'(c0_rsp_n - rsp_before), 64'd0);
        chk("rst_inflight_cnt", {rd_cnt, wr_cnt}, 64'd0);
        chk("rst_inflight_err", 64'({err_overflow, err_bad_type}), 64'd0);

        // Streaming: 1000 back-to-back reads, each at latency 9 means one per cycle
        almfull_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            set_rd(42'h10, 16'(i), RDLINE_I, 1'b1, DATA_A5, 9);
            step();
            if (c0_almfull !== 1'b0) almfull_seen++;
        end
        idle(15);
        chk("stream_rd_cnt", 64'(rd_cnt), 64'd1000);
        chk("stream_almfull", 64'(almfull_seen), 64'd0);
        chk("stream_rd_pending", 64'(exp_rd.size()), 64'd0);
        chk("final_wr_pending", 64'(exp_wr.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
